// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for mem_port_arbiter: fetch and data requester ports, memory port, stall/err.
// slave = the arbiter itself, master = the surrounding core datapath plus memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MASK_W = 8
);
  logic              i_req_valid;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_req_ready;
  logic              i_resp_valid;
  logic [DATA_W-1:0] i_resp_data;

  logic              d_req_valid;
  logic              d_req_we;
  logic [ADDR_W-1:0] d_req_addr;
  logic [DATA_W-1:0] d_req_wdata;
  logic [MASK_W-1:0] d_req_wmask;
  logic              d_req_ready;
  logic              d_resp_valid;
  logic [DATA_W-1:0] d_resp_rdata;

  logic              m_req_valid;
  logic              m_req_ready;
  logic              m_req_we;
  logic [ADDR_W-1:0] m_req_addr;
  logic [DATA_W-1:0] m_req_wdata;
  logic [MASK_W-1:0] m_req_wmask;
  logic              m_resp_valid;
  logic [DATA_W-1:0] m_resp_data;

  logic              stall;
  logic              err;

  modport slave (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_resp_valid, i_resp_data,
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wmask,
    output d_req_ready, d_resp_valid, d_resp_rdata,
    output m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_wmask,
    input  m_req_ready, m_resp_valid, m_resp_data,
    output stall, err
  );

  modport master (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_resp_valid, i_resp_data,
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wmask,
    input  d_req_ready, d_resp_valid, d_resp_rdata,
    input  m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_wmask,
    output m_req_ready, m_resp_valid, m_resp_data,
    input  stall, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data load/store, one access at a time.
// Define ROUND_ROBIN_EN to alternate grants on ties; otherwise data always wins a tie.
//
//   state | meaning
//   IDLE  | no access in flight; arbitrate and capture the winning request
//   ISSUE | m_req_valid held from captured fields until the memory accepts
//   WAIT  | request accepted, waiting for m_resp_valid
//   RESP  | one-cycle response pulse to the granted requester
module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MASK_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);

  localparam int               CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam bit               TO_EN  = (TIMEOUT > 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              gnt_data_q, gnt_data_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] i_data_q, i_data_d;
  logic [DATA_W-1:0] d_data_q, d_data_d;
`ifdef ROUND_ROBIN_EN
  logic              last_data_q, last_data_d;
`endif

  logic pick_data, timeout;
  logic i_rdy, d_rdy, m_vld, i_rsp, d_rsp, to_err;

  always_comb begin
    state_d    = state_q;
    gnt_data_d = gnt_data_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    cnt_d      = cnt_q;
    i_data_d   = i_data_q;
    d_data_d   = d_data_q;
`ifdef ROUND_ROBIN_EN
    last_data_d = last_data_q;
`endif
    pick_data = 1'b0;
    i_rdy     = 1'b0;
    d_rdy     = 1'b0;
    m_vld     = 1'b0;
    i_rsp     = 1'b0;
    d_rsp     = 1'b0;
    to_err    = 1'b0;

    timeout = TO_EN && (state_q == ISSUE || state_q == WAIT) && (cnt_q == TO_VAL);

    if (state_q == ISSUE || state_q == WAIT) cnt_d = cnt_q + CNT_W'(1);

    if (timeout) begin
      // Abort: answer the granted requester with zero data; any same-cycle reply is dropped.
      to_err  = 1'b1;
      i_rsp   = !gnt_data_q;
      d_rsp   = gnt_data_q;
      if (gnt_data_q) d_data_d = '0;
      else            i_data_d = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.d_req_valid || bus.i_req_valid) begin
`ifdef ROUND_ROBIN_EN
            pick_data   = bus.d_req_valid && (!bus.i_req_valid || !last_data_q);
            last_data_d = pick_data;
`else
            pick_data   = bus.d_req_valid;
`endif
            d_rdy      = pick_data;
            i_rdy      = !pick_data;
            gnt_data_d = pick_data;
            we_d       = pick_data && bus.d_req_we;
            addr_d     = pick_data ? bus.d_req_addr : bus.i_req_addr;
            wdata_d    = (pick_data && bus.d_req_we) ? bus.d_req_wdata : '0;
            wmask_d    = (pick_data && bus.d_req_we) ? bus.d_req_wmask : '0;
            cnt_d      = '0;
            state_d    = ISSUE;
          end
        end
        ISSUE: begin
          m_vld = 1'b1;
          if (bus.m_req_ready) state_d = WAIT;
        end
        WAIT: begin
          if (bus.m_resp_valid) begin
            if (gnt_data_q) d_data_d = we_q ? '0 : bus.m_resp_data;
            else            i_data_d = bus.m_resp_data;
            state_d = RESP;
          end
        end
        RESP: begin
          i_rsp   = !gnt_data_q;
          d_rsp   = gnt_data_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_data_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      cnt_q      <= '0;
      i_data_q   <= '0;
      d_data_q   <= '0;
`ifdef ROUND_ROBIN_EN
      last_data_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_data_q <= gnt_data_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      cnt_q      <= cnt_d;
      i_data_q   <= i_data_d;
      d_data_q   <= d_data_d;
`ifdef ROUND_ROBIN_EN
      last_data_q <= last_data_d;
`endif
    end
  end

  // Input-dependent outputs are masked by reset so everything reads 0 while rst is low.
  assign bus.i_req_ready  = rst && i_rdy;
  assign bus.d_req_ready  = rst && d_rdy;
  assign bus.stall        = rst && ((state_q != IDLE) || bus.i_req_valid || bus.d_req_valid);
  assign bus.i_resp_valid = i_rsp;
  assign bus.d_resp_valid = d_rsp;
  assign bus.i_resp_data  = (timeout && !gnt_data_q) ? '0 : i_data_q;
  assign bus.d_resp_rdata = (timeout && gnt_data_q) ? '0 : d_data_q;
  assign bus.err          = to_err;
  assign bus.m_req_valid  = m_vld;
  assign bus.m_req_we     = we_q;
  assign bus.m_req_addr   = addr_q;
  assign bus.m_req_wdata  = wdata_q;
  assign bus.m_req_wmask  = wmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random requesters and memory, reference model predicts grants and replies.
module tb_mem_port_arbiter;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int MW  = 8;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) bus();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } req_t;

  typedef struct {
    bit          is_d;
    logic [63:0] data;
    bit          err;
  } rsp_t;

  req_t acc_q[$];
  rsp_t exp_q[$];
  bit   grant_log[$];

  int vec  = 0;
  int errs = 0;
  int i_done = 0;
  int d_done = 0;
  bit busy   = 0;
  bit last_d = 0;

  bit          force_en = 0;
  int          f_r = 0;
  int          f_w = 0;
  bit          f_never = 0;
  logic [63:0] f_data = '0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void flag(string name);
    vec++;
    errs++;
    $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
  endfunction

  function automatic void check_all_zero(string t);
    chk({t, "_i_req_ready"},  bus.i_req_ready,  0);
    chk({t, "_i_resp_valid"}, bus.i_resp_valid, 0);
    chk({t, "_i_resp_data"},  bus.i_resp_data,  0);
    chk({t, "_d_req_ready"},  bus.d_req_ready,  0);
    chk({t, "_d_resp_valid"}, bus.d_resp_valid, 0);
    chk({t, "_d_resp_rdata"}, bus.d_resp_rdata, 0);
    chk({t, "_m_req_valid"},  bus.m_req_valid,  0);
    chk({t, "_m_req_we"},     bus.m_req_we,     0);
    chk({t, "_m_req_addr"},   bus.m_req_addr,   0);
    chk({t, "_m_req_wdata"},  bus.m_req_wdata,  0);
    chk({t, "_m_req_wmask"},  bus.m_req_wmask,  0);
    chk({t, "_stall"},        bus.stall,        0);
    chk({t, "_err"},          bus.err,          0);
  endfunction

  // Monitor: arbitration/stall model every cycle, response scoreboard on every pulse.
  initial begin
    bit   ei, ed;
    rsp_t e;
    req_t q;
    forever begin
      @(negedge clk);
      if (rst) begin
        ei = 0;
        ed = 0;
        if (!busy) begin
          if (bus.d_req_valid && bus.i_req_valid) begin
`ifdef ROUND_ROBIN_EN
            ed = !last_d;
`else
            ed = 1;
`endif
            ei = !ed;
          end else begin
            ed = bus.d_req_valid;
            ei = bus.i_req_valid;
          end
        end
        chk("i_req_ready", bus.i_req_ready, ei);
        chk("d_req_ready", bus.d_req_ready, ed);
        chk("stall", bus.stall, busy || bus.i_req_valid || bus.d_req_valid);
        if (bus.i_resp_valid || bus.d_resp_valid || bus.err) begin
          if (exp_q.size() == 0) begin
            flag("unexpected_response");
          end else begin
            e = exp_q.pop_front();
            chk("resp_sel_i", bus.i_resp_valid, !e.is_d);
            chk("resp_sel_d", bus.d_resp_valid, e.is_d);
            chk("resp_data", e.is_d ? bus.d_resp_rdata : bus.i_resp_data, e.data);
            chk("resp_err", bus.err, e.err);
            busy = 0;
            if (e.is_d) d_done++;
            else        i_done++;
          end
        end
        if (ei || ed) begin
          busy     = 1;
          last_d   = ed;
          q.is_d   = ed;
          q.we     = ed && bus.d_req_we;
          q.addr   = ed ? bus.d_req_addr : bus.i_req_addr;
          q.wdata  = bus.d_req_wdata;
          q.wmask  = q.we ? bus.d_req_wmask : 8'h00;
          acc_q.push_back(q);
          grant_log.push_back(ed);
        end
      end
    end
  end

  // Memory model: picks accept delay r and reply delay w; cycle c counts from the first ISSUE cycle.
  initial begin
    req_t        a;
    int          r, w, rc, e;
    bit          never, to, aborted, late;
    logic [63:0] data;
    rsp_t        x;
    late = 0;
    bus.m_req_ready  = 0;
    bus.m_resp_valid = 0;
    bus.m_resp_data  = '0;
    forever begin
      @(negedge clk);
      bus.m_req_ready  = 0;
      bus.m_resp_valid = late;
      bus.m_resp_data  = {$urandom, $urandom};
      late = 0;
      if (rst && bus.m_req_valid) begin
        if (acc_q.size() == 0) begin
          flag("m_req_without_accept");
          a = '{default: '0};
        end else begin
          a = acc_q.pop_front();
        end
        if (force_en) begin
          r = f_r; w = f_w; never = f_never; data = f_data;
        end else begin
          r     = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 3);
          w     = $urandom_range(0, 3);
          never = ($urandom_range(0, 7) == 0);
          data  = {$urandom, $urandom};
        end
        rc = r + 1 + w;
        to = never || (r >= TMO) || (rc >= TMO);
        e  = to ? TMO : rc;
        x.is_d = a.is_d;
        x.err  = to;
        x.data = (to || a.we) ? 64'h0 : data;
        exp_q.push_back(x);
        aborted = 0;
        for (int c = 0; c <= e; c++) begin
          if (c > 0) begin
            @(negedge clk);
            if (!rst) begin
              aborted = 1;
              break;
            end
          end
          if (c <= r && c < TMO) begin
            chk("m_req_valid", bus.m_req_valid, 1);
            chk("m_req_addr", bus.m_req_addr, a.addr);
            chk("m_req_we", bus.m_req_we, a.we);
            chk("m_req_wmask", bus.m_req_wmask, a.wmask);
            if (a.we) chk("m_req_wdata", bus.m_req_wdata, a.wdata);
          end else begin
            chk("m_req_valid_low", bus.m_req_valid, 0);
          end
          chk("err_timing", bus.err, (to && c == TMO) ? 1 : 0);
          bus.m_req_ready  = (c == r);
          bus.m_resp_valid = (!never && c == rc) || (c <= r && $urandom_range(0, 1) == 1);
          bus.m_resp_data  = (c == rc) ? data : {$urandom, $urandom};
        end
        if (!aborted) late = to;
      end
    end
  end

  task automatic fetch_one(input logic [63:0] a);
    int n;
    int start;
    @(posedge clk); #1;
    bus.i_req_valid = 1;
    bus.i_req_addr  = a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.i_req_ready && n < 200);
    if (!bus.i_req_ready) flag("fetch_accept_wait");
    start = i_done;
    @(posedge clk); #1;
    bus.i_req_valid = 0;
    n = 0;
    while (i_done == start && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (i_done == start) flag("fetch_resp_wait");
  endtask

  task automatic data_one(input bit we, input logic [63:0] a, input logic [63:0] wd, input logic [7:0] wm);
    int n;
    int start;
    @(posedge clk); #1;
    bus.d_req_valid = 1;
    bus.d_req_we    = we;
    bus.d_req_addr  = a;
    bus.d_req_wdata = wd;
    bus.d_req_wmask = wm;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.d_req_ready && n < 200);
    if (!bus.d_req_ready) flag("data_accept_wait");
    start = d_done;
    @(posedge clk); #1;
    bus.d_req_valid = 0;
    n = 0;
    while (d_done == start && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (d_done == start) flag("data_resp_wait");
  endtask

  task automatic fetch_min(input logic [63:0] a, input logic [63:0] d);
    int lat;
    force_en = 1; f_r = 0; f_w = 0; f_never = 0; f_data = d;
    @(posedge clk); #1;
    bus.i_req_valid = 1;
    bus.i_req_addr  = a;
    @(negedge clk);
    chk("min_i_req_ready_c0", bus.i_req_ready, 1);
    @(posedge clk); #1;
    bus.i_req_valid = 0;
    @(negedge clk);
    chk("min_m_req_valid_c1", bus.m_req_valid, 1);
    chk("min_m_req_addr_c1", bus.m_req_addr, a);
    lat = 1;
    while (!bus.i_resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("min_resp_latency", lat, 3);
    chk("min_resp_data", bus.i_resp_data, d);
    @(negedge clk);
    chk("min_stall_c4", bus.stall, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    errs++;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $fatal(1, "watchdog");
  end

  initial begin
    bit [3:0] pat;
    bus.i_req_valid = 0; bus.i_req_addr = '0;
    bus.d_req_valid = 0; bus.d_req_we = 0; bus.d_req_addr = '0;
    bus.d_req_wdata = '0; bus.d_req_wmask = '0;

    #3;
    bus.i_req_valid = 1;
    bus.d_req_valid = 1;
    #1;
    check_all_zero("por");
    bus.i_req_valid = 0;
    bus.d_req_valid = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1;

    fetch_min(64'h1000, 64'hDEAD_BEEF_0000_0013);

    force_en = 1; f_r = 0; f_w = 1; f_never = 0; f_data = 64'h1111_2222_3333_4444;
    data_one(1, 64'h2008, 64'h55, 8'h01);
    f_data = 64'hCAFE_F00D_1234_5678;
    data_one(0, 64'h2010, 64'h0, 8'h00);

    force_en = 0;
    grant_log.delete();
    fork
      begin
        data_one(1, 64'h3000, 64'hAA, 8'hFF);
        data_one(0, 64'h3008, 64'h0, 8'h00);
      end
      begin
        fetch_one(64'h0100);
        fetch_one(64'h0108);
      end
    join
`ifdef ROUND_ROBIN_EN
    pat = 4'b0101;
`else
    pat = 4'b0011;
`endif
    chk("tie_grant_count", grant_log.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < grant_log.size()) chk($sformatf("tie_grant_%0d", k), grant_log[k], pat[k]);

    force_en = 1; f_r = 3; f_w = 0; f_never = 0; f_data = 64'h0123_4567_89AB_CDEF;
    fetch_one(64'h5000);

    f_r = 0; f_never = 1;
    fetch_one(64'h6000);
    f_r = 9; f_never = 0;
    data_one(0, 64'h6008, 64'h0, 8'h00);
    f_r = 1; f_w = 2; f_data = 64'h7777_0000_7777_0000;
    fetch_one(64'h6010);

    f_r = 0; f_w = 0; f_never = 1;
    @(posedge clk); #1;
    bus.i_req_valid = 1;
    bus.i_req_addr  = 64'h3000;
    @(negedge clk);
    chk("rst_test_accept", bus.i_req_ready, 1);
    @(posedge clk); #1;
    bus.i_req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    #2;
    bus.i_req_valid = 1;
    bus.d_req_valid = 1;
    rst = 0;
    #1;
    check_all_zero("async_rst");
    bus.i_req_valid = 0;
    bus.d_req_valid = 0;
    repeat (2) @(posedge clk);
    #2;
    exp_q.delete();
    acc_q.delete();
    grant_log.delete();
    busy   = 0;
    last_d = 0;
    #2 rst = 1;
    fetch_min(64'h4000, 64'h0BAD_C0DE_FEED_0001);

    force_en = 0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          fetch_one({$urandom, $urandom} & ~64'h7);
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          data_one($urandom_range(0, 1) == 1, {$urandom, $urandom} & ~64'h7,
                   {$urandom, $urandom}, 8'($urandom));
        end
      end
    join
    repeat (4) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
